// File: rtl/cam_pixel_packer_if.sv
// Camera-side input pins and packed-pixel output bundle for cam_pixel_packer.
// The packer attaches through the slave modport; the camera/sink side uses master.
interface cam_pixel_packer_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 2,
    parameter int CNT_W = 12
) ();
    logic                  vsync_i;
    logic                  href_i;
    logic [IN_W-1:0]       data_i;
    logic [IN_W*RATIO-1:0] data_o;
    logic                  data_de_o;
    logic                  sof_o;
    logic                  eol_o;
    logic                  frame_done_o;
    logic                  hblank_o;
    logic [CNT_W-1:0]      line_cnt_o;
    logic [CNT_W-1:0]      pix_cnt_o;
    logic                  partial_err_o;

    modport master (
        output vsync_i, href_i, data_i,
        input  data_o, data_de_o, sof_o, eol_o, frame_done_o, hblank_o,
        input  line_cnt_o, pix_cnt_o, partial_err_o
    );

    modport slave (
        input  vsync_i, href_i, data_i,
        output data_o, data_de_o, sof_o, eol_o, frame_done_o, hblank_o,
        output line_cnt_o, pix_cnt_o, partial_err_o
    );
endinterface

// File: rtl/cam_pixel_packer.sv
// DVP capture front end: packs RATIO camera beats into one pixel word, tracks
// frame/line boundaries and reports words per line, lines per frame and partial lines.
module cam_pixel_packer #(
    parameter int IN_W        = 8,
    parameter int RATIO       = 2,
    parameter int BIG_ENDIAN  = 1,
    parameter int PAD_PARTIAL = 1,
    parameter int CNT_W       = 12
) (
    input logic           pixel_clk,
    input logic           rst,
    cam_pixel_packer_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int BC_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(RATIO - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             vsync_q;
    logic             href_q;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             de_q, de_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             fd_q, fd_d;
    logic             eol_pend_q, eol_pend_d;
    logic             sof_pend_q, sof_pend_d;
    logic [CNT_W-1:0] line_q, line_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic             perr_q, perr_d;

    logic vsync_rise_s;
    logic vsync_fall_s;
    logic href_rise_s;
    logic href_fall_s;

    function automatic logic [OUT_W-1:0] place_beat(input logic [OUT_W-1:0] acc,
                                                    input logic [IN_W-1:0]  beat,
                                                    input logic [BC_W-1:0]  slot);
        logic [OUT_W-1:0] res;
        res = acc;
        for (int s = 0; s < RATIO; s++) begin
            if (slot == BC_W'(s)) begin
                if (BIG_ENDIAN != 0) begin
                    res[(RATIO-1-s)*IN_W +: IN_W] = beat;
                end else begin
                    res[s*IN_W +: IN_W] = beat;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign vsync_rise_s = bus.vsync_i & ~vsync_q;
    assign vsync_fall_s = ~bus.vsync_i & vsync_q;
    assign href_rise_s  = bus.href_i & ~href_q;
    assign href_fall_s  = ~bus.href_i & href_q;

    // Next-state, packing and counter logic for the frame/line state machine.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        data_d     = {OUT_W{1'b0}};
        de_d       = 1'b0;
        sof_d      = 1'b0;
        eol_d      = 1'b0;
        fd_d       = 1'b0;
        eol_pend_d = 1'b0;
        sof_pend_d = sof_pend_q;
        line_d     = line_q;
        pix_d      = pix_q;
        perr_d     = perr_q;
        case (state_q)
            IDLE: begin
                if (bus.vsync_i) begin
                    state_d = VBLANK;
                end else begin
                    state_d = IDLE;
                end
            end
            VBLANK: begin
                if (vsync_fall_s) begin
                    state_d    = ACTIVE;
                    line_d     = {CNT_W{1'b0}};
                    sof_pend_d = 1'b1;
                end else begin
                    state_d = VBLANK;
                end
            end
            ACTIVE: begin
                if (vsync_rise_s) begin
                    // Frame cut short: the line in progress is dropped without eol or pad.
                    state_d    = VBLANK;
                    fd_d       = 1'b1;
                    beat_cnt_d = {BC_W{1'b0}};
                    acc_d      = {OUT_W{1'b0}};
                end else begin
                    if (eol_pend_q) begin
                        eol_d  = 1'b1;
                        line_d = sat_inc(line_q);
                        perr_d = perr_q | (beat_cnt_q != {BC_W{1'b0}});
                        if ((beat_cnt_q != {BC_W{1'b0}}) && (PAD_PARTIAL != 0)) begin
                            data_d = acc_q;
                            de_d   = 1'b1;
                            pix_d  = sat_inc(pix_q);
                        end else begin
                            de_d = 1'b0;
                        end
                        beat_cnt_d = {BC_W{1'b0}};
                        acc_d      = {OUT_W{1'b0}};
                    end else begin
                        eol_d = 1'b0;
                    end
                    // A new line may start on the very edge that closes the previous one.
                    pix_d = href_rise_s ? {CNT_W{1'b0}} : pix_d;
                    if (bus.href_i) begin
                        acc_d = place_beat(acc_d, bus.data_i, beat_cnt_d);
                        if (beat_cnt_d == LAST_BEAT) begin
                            data_d     = acc_d;
                            de_d       = 1'b1;
                            pix_d      = sat_inc(pix_d);
                            beat_cnt_d = {BC_W{1'b0}};
                            acc_d      = {OUT_W{1'b0}};
                        end else begin
                            beat_cnt_d = beat_cnt_d + BC_W'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_d;
                    end
                    eol_pend_d = href_fall_s;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = {BC_W{1'b0}};
                acc_d      = {OUT_W{1'b0}};
            end
        endcase
        if (de_d && sof_pend_d) begin
            sof_d      = 1'b1;
            sof_pend_d = 1'b0;
        end else begin
            sof_d = 1'b0;
        end
    end

    // State, input sample and output registers.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            beat_cnt_q <= {BC_W{1'b0}};
            acc_q      <= {OUT_W{1'b0}};
            data_q     <= {OUT_W{1'b0}};
            de_q       <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            fd_q       <= 1'b0;
            eol_pend_q <= 1'b0;
            sof_pend_q <= 1'b0;
            line_q     <= {CNT_W{1'b0}};
            pix_q      <= {CNT_W{1'b0}};
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= bus.vsync_i;
            href_q     <= bus.href_i;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
            data_q     <= data_d;
            de_q       <= de_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            fd_q       <= fd_d;
            eol_pend_q <= eol_pend_d;
            sof_pend_q <= sof_pend_d;
            line_q     <= line_d;
            pix_q      <= pix_d;
            perr_q     <= perr_d;
        end
    end

    assign bus.data_o        = data_q;
    assign bus.data_de_o     = de_q;
    assign bus.sof_o         = sof_q;
    assign bus.eol_o         = eol_q;
    assign bus.frame_done_o  = fd_q;
    assign bus.hblank_o      = href_q;
    assign bus.line_cnt_o    = line_q;
    assign bus.pix_cnt_o     = pix_q;
    assign bus.partial_err_o = perr_q;
endmodule

// File: tb/tb_cam_pixel_packer.sv
// Bench for cam_pixel_packer: three configurations share one camera stream and are
// compared every cycle against a queue-of-beats reference model.
module tb_cam_pixel_packer;
    localparam int NI = 3;
    localparam int CFG_RATIO [NI] = '{2, 4, 1};
    localparam int CFG_BE    [NI] = '{1, 0, 1};
    localparam int CFG_PAD   [NI] = '{1, 0, 1};
    localparam int CFG_MAX   [NI] = '{4095, 4095, 7};

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0;
    logic       hr = 1'b0;
    logic [7:0] dat = 8'h00;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 pixel_clk = ~pixel_clk;

    cam_pixel_packer_if #(.IN_W(8), .RATIO(2), .CNT_W(12)) if0 ();
    cam_pixel_packer_if #(.IN_W(8), .RATIO(4), .CNT_W(12)) if1 ();
    cam_pixel_packer_if #(.IN_W(8), .RATIO(1), .CNT_W(3))  if2 ();

    assign if0.vsync_i = vs;
    assign if0.href_i  = hr;
    assign if0.data_i  = dat;
    assign if1.vsync_i = vs;
    assign if1.href_i  = hr;
    assign if1.data_i  = dat;
    assign if2.vsync_i = vs;
    assign if2.href_i  = hr;
    assign if2.data_i  = dat;

    cam_pixel_packer #(.IN_W(8), .RATIO(2), .BIG_ENDIAN(1), .PAD_PARTIAL(1), .CNT_W(12))
        dut0 (.pixel_clk(pixel_clk), .rst(rst), .bus(if0.slave));
    cam_pixel_packer #(.IN_W(8), .RATIO(4), .BIG_ENDIAN(0), .PAD_PARTIAL(0), .CNT_W(12))
        dut1 (.pixel_clk(pixel_clk), .rst(rst), .bus(if1.slave));
    cam_pixel_packer #(.IN_W(8), .RATIO(1), .BIG_ENDIAN(1), .PAD_PARTIAL(1), .CNT_W(3))
        dut2 (.pixel_clk(pixel_clk), .rst(rst), .bus(if2.slave));

    // reference model state, one entry per configuration
    bit          m_armed [NI];
    bit          m_frame [NI];
    bit          m_eol_due [NI];
    bit          m_sof_pend [NI];
    bit          m_perr [NI];
    bit          m_pv [NI];
    bit          m_ph [NI];
    int          m_line [NI];
    int          m_pix [NI];
    int          m_nb [NI];
    logic [7:0]  m_beat [NI][4];
    logic [31:0] e_data [NI];
    bit          e_de [NI];
    bit          e_sof [NI];
    bit          e_eol [NI];
    bit          e_fd [NI];
    bit          e_hb [NI];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int sof0_n, eol0_n, fd0_n, pad0_n;
    int nl, len, cut;
    bit aborted;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_armed[k] = 0; m_frame[k] = 0; m_eol_due[k] = 0; m_sof_pend[k] = 0;
            m_perr[k] = 0; m_pv[k] = 0; m_ph[k] = 0;
            m_line[k] = 0; m_pix[k] = 0; m_nb[k] = 0;
        end
    endtask

    function automatic logic [31:0] pack_word(input int k);
        logic [31:0] w;
        int sh;
        w = 32'd0;
        for (int j = 0; j < m_nb[k]; j++) begin
            sh = (CFG_BE[k] != 0) ? 8 * (CFG_RATIO[k] - 1 - j) : 8 * j;
            w = w | (32'(m_beat[k][j]) << sh);
        end
        return w;
    endfunction

    task automatic emit(input int k, input logic [31:0] w);
        e_de[k] = 1;
        e_data[k] = w;
        if (m_pix[k] < CFG_MAX[k]) m_pix[k]++;
        if (m_sof_pend[k]) begin
            e_sof[k] = 1;
            m_sof_pend[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input bit h, input logic [7:0] d);
        e_data[k] = 32'd0; e_de[k] = 0; e_sof[k] = 0; e_eol[k] = 0; e_fd[k] = 0;
        e_hb[k] = h;
        if (!m_armed[k]) begin
            m_armed[k] = v;
        end else if (!m_frame[k]) begin
            if (m_pv[k] && !v) begin
                m_frame[k] = 1; m_line[k] = 0; m_sof_pend[k] = 1;
            end
        end else if (v && !m_pv[k]) begin
            m_frame[k] = 0; e_fd[k] = 1; m_nb[k] = 0; m_eol_due[k] = 0;
        end else begin
            if (m_eol_due[k]) begin
                e_eol[k] = 1;
                if (m_line[k] < CFG_MAX[k]) m_line[k]++;
                if (m_nb[k] != 0) begin
                    m_perr[k] = 1;
                    if (CFG_PAD[k] != 0) emit(k, pack_word(k));
                end
                m_nb[k] = 0;
            end
            m_eol_due[k] = m_ph[k] && !h;
            if (h && !m_ph[k]) m_pix[k] = 0;
            if (h) begin
                m_beat[k][m_nb[k]] = d;
                m_nb[k]++;
                if (m_nb[k] == CFG_RATIO[k]) begin
                    emit(k, pack_word(k));
                    m_nb[k] = 0;
                end
            end
        end
        m_pv[k] = v;
        m_ph[k] = h;
    endtask

    task automatic chk_inst(input int k, input logic [31:0] data, input logic de, input logic sof,
                            input logic eol, input logic fd, input logic hb,
                            input logic [31:0] line, input logic [31:0] pix, input logic perr);
        check_value($sformatf("u%0d.data_o", k), data, e_data[k]);
        check_value($sformatf("u%0d.data_de_o", k), 32'(de), 32'(e_de[k]));
        check_value($sformatf("u%0d.sof_o", k), 32'(sof), 32'(e_sof[k]));
        check_value($sformatf("u%0d.eol_o", k), 32'(eol), 32'(e_eol[k]));
        check_value($sformatf("u%0d.frame_done_o", k), 32'(fd), 32'(e_fd[k]));
        check_value($sformatf("u%0d.hblank_o", k), 32'(hb), 32'(e_hb[k]));
        check_value($sformatf("u%0d.line_cnt_o", k), line, 32'(m_line[k]));
        check_value($sformatf("u%0d.pix_cnt_o", k), pix, 32'(m_pix[k]));
        check_value($sformatf("u%0d.partial_err_o", k), 32'(perr), 32'(m_perr[k]));
    endtask

    task automatic compare_all();
        chk_inst(0, 32'(if0.data_o), if0.data_de_o, if0.sof_o, if0.eol_o, if0.frame_done_o,
                 if0.hblank_o, 32'(if0.line_cnt_o), 32'(if0.pix_cnt_o), if0.partial_err_o);
        chk_inst(1, 32'(if1.data_o), if1.data_de_o, if1.sof_o, if1.eol_o, if1.frame_done_o,
                 if1.hblank_o, 32'(if1.line_cnt_o), 32'(if1.pix_cnt_o), if1.partial_err_o);
        chk_inst(2, 32'(if2.data_o), if2.data_de_o, if2.sof_o, if2.eol_o, if2.frame_done_o,
                 if2.hblank_o, 32'(if2.line_cnt_o), 32'(if2.pix_cnt_o), if2.partial_err_o);
        if (if0.data_de_o) q0.push_back(32'(if0.data_o));
        if (if1.data_de_o) q1.push_back(32'(if1.data_o));
        if (if0.sof_o) sof0_n++;
        if (if0.eol_o) eol0_n++;
        if (if0.frame_done_o) fd0_n++;
        if (if0.eol_o && if0.data_de_o) pad0_n++;
    endtask

    task automatic zero_check(input string tag);
        check_value({tag, ".u0.data_o"}, 32'(if0.data_o), 32'd0);
        check_value({tag, ".u0.de"}, 32'(if0.data_de_o), 32'd0);
        check_value({tag, ".u0.hblank"}, 32'(if0.hblank_o), 32'd0);
        check_value({tag, ".u0.line"}, 32'(if0.line_cnt_o), 32'd0);
        check_value({tag, ".u0.pix"}, 32'(if0.pix_cnt_o), 32'd0);
        check_value({tag, ".u0.perr"}, 32'(if0.partial_err_o), 32'd0);
        check_value({tag, ".u0.flags"}, 32'({if0.sof_o, if0.eol_o, if0.frame_done_o}), 32'd0);
        check_value({tag, ".u1.data_o"}, 32'(if1.data_o), 32'd0);
        check_value({tag, ".u1.rest"}, 32'({if1.data_de_o, if1.sof_o, if1.eol_o, if1.frame_done_o,
                    if1.hblank_o, if1.partial_err_o}), 32'd0);
        check_value({tag, ".u1.cnt"}, 32'({if1.line_cnt_o, if1.pix_cnt_o}), 32'd0);
        check_value({tag, ".u2.all"}, 32'({if2.data_o, if2.data_de_o, if2.sof_o, if2.eol_o,
                    if2.frame_done_o, if2.hblank_o, if2.partial_err_o}), 32'd0);
        check_value({tag, ".u2.cnt"}, 32'({if2.line_cnt_o, if2.pix_cnt_o}), 32'd0);
    endtask

    task automatic cyc(input logic v, input logic h, input logic [7:0] d);
        vs = v; hr = h; dat = d;
        @(posedge pixel_clk);
        for (int k = 0; k < NI; k++) model_step(k, v, h, d);
        @(negedge pixel_clk);
        compare_all();
    endtask

    task automatic blank(input int n, input logic v);
        for (int i = 0; i < n; i++) cyc(v, 1'b0, 8'($urandom));
    endtask

    task automatic line_mult(input int n, input int mult);
        for (int j = 0; j < n; j++) cyc(1'b0, 1'b1, 8'((j + 1) * mult));
    endtask

    task automatic clear_logs();
        q0.delete(); q1.delete();
        sof0_n = 0; eol0_n = 0; fd0_n = 0; pad0_n = 0;
    endtask

    function automatic logic [31:0] get0(input int i);
        return (i < q0.size()) ? q0[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] get1(input int i);
        return (i < q1.size()) ? q1[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        clear_logs();
        @(negedge pixel_clk);
        zero_check("por");
        rst = 1'b0;

        // vsync low after reset: href activity must not be captured
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'(i % 3 != 0), 8'($urandom));
        check_value("idle.no_words", 32'(q0.size() + q1.size()), 32'd0);

        blank(2, 1'b1);
        blank(2, 1'b0);
        clear_logs();
        line_mult(4, 8'h11);
        blank(4, 1'b0);
        check_value("A.n_words", 32'(q0.size()), 32'd2);
        check_value("A.word0", get0(0), 32'h1122);
        check_value("A.word1", get0(1), 32'h3344);
        check_value("A.sof_count", 32'(sof0_n), 32'd1);
        check_value("A.eol_count", 32'(eol0_n), 32'd1);
        check_value("A.pix_cnt", 32'(if0.pix_cnt_o), 32'd2);
        check_value("A.line_cnt", 32'(if0.line_cnt_o), 32'd1);
        check_value("A.r4_word", get1(0), 32'h4433_2211);

        clear_logs();
        line_mult(5, 8'h11);
        blank(4, 1'b0);
        check_value("B.n_words", 32'(q0.size()), 32'd3);
        check_value("B.pad_word", get0(2), 32'h5500);
        check_value("B.pad_with_eol", 32'(pad0_n), 32'd1);
        check_value("B.perr", 32'(if0.partial_err_o), 32'd1);
        check_value("B.r4_n_words", 32'(q1.size()), 32'd1);

        clear_logs();
        line_mult(4, 1);
        blank(4, 1'b0);
        check_value("C.r4_le_word", get1(0), 32'h0403_0201);

        clear_logs();
        line_mult(6, 1);
        blank(4, 1'b0);
        check_value("D.r4_n_words", 32'(q1.size()), 32'd1);
        check_value("D.r4_perr", 32'(if1.partial_err_o), 32'd1);
        check_value("D.perr_sticky", 32'(if0.partial_err_o), 32'd1);

        // vsync rises mid-line after three beats
        clear_logs();
        line_mult(3, 8'h11);
        cyc(1'b1, 1'b1, 8'h44);
        blank(3, 1'b1);
        check_value("E.frame_done", 32'(fd0_n), 32'd1);
        check_value("E.no_eol", 32'(eol0_n), 32'd0);
        check_value("E.n_words", 32'(q0.size()), 32'd1);
        blank(1, 1'b0);
        check_value("E.line_cleared", 32'(if0.line_cnt_o), 32'd0);

        // saturation of the 3-bit counters
        for (int l = 0; l < 9; l++) begin
            for (int j = 0; j < 9; j++) cyc(1'b0, 1'b1, 8'($urandom));
            blank(2, 1'b0);
        end
        check_value("F.line_sat", 32'(if2.line_cnt_o), 32'd7);
        check_value("F.pix_sat", 32'(if2.pix_cnt_o), 32'd7);
        check_value("F.line_wide", 32'(if0.line_cnt_o), 32'd9);
        blank(2, 1'b1);

        repeat (15) begin
            blank($urandom_range(1, 3), 1'b1);
            blank($urandom_range(1, 3), 1'b0);
            nl = $urandom_range(1, 8);
            aborted = 0;
            for (int l = 0; l < nl && !aborted; l++) begin
                len = $urandom_range(1, 12);
                cut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
                for (int j = 0; j < len && !aborted; j++) begin
                    if (j == cut) begin
                        cyc(1'b1, 1'b1, 8'($urandom));
                        aborted = 1;
                    end else begin
                        cyc(1'b0, 1'b1, 8'($urandom));
                    end
                end
                if (!aborted) blank($urandom_range(1, 4), 1'b0);
            end
        end

        // asynchronous reset while a word is on the output
        blank(2, 1'b1);
        blank(1, 1'b0);
        for (int i = 0; i < 20 && !if0.data_de_o; i++) cyc(1'b0, 1'b1, 8'($urandom));
        check_value("G.word_present", 32'(if0.data_de_o), 32'd1);
        rst = 1'b1;
        #1;
        zero_check("arst");
        model_reset();
        vs = 1'b0; hr = 1'b0;
        repeat (2) @(negedge pixel_clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'(i % 2), 8'($urandom));
        check_value("G.perr_cleared", 32'(if0.partial_err_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
